// File: rtl/load_store_unit.sv
// Load/store unit: drives a req/ack data bus from the execute stage and stalls the core until the access completes.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses trap without a bus request.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t        state;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [CW-1:0] tmo_cnt;

    logic          op_req;
    logic          trap;
    logic          timeout_hit;
    logic [3:0]    be_next;
    logic [31:0]   wd_next;
    logic [1:0]    lane;
    logic [31:0]   shifted;
    logic [31:0]   fmt_rdata;

    assign op_req      = mem_read | mem_write;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == CNT_LAST);

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        be_next = 4'b1111;
        wd_next = wdata;
        unique case (func3[1:0])
            2'b00: begin
                be_next = 4'b0001 << addr[1:0];
                wd_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next = 4'b0011 << {addr[1], 1'b0};
                wd_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        trap = 1'b0;
        unique case (func3[1:0])
            2'b00:   trap = 1'b0;
            2'b01:   trap = addr[0];
            default: trap = |addr[1:0];
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Load path works from the captured func3/offset, so it is stable for the whole REQ phase.
    always_comb begin
        lane      = 2'b00;
        fmt_rdata = bus_rdata;
        unique case (f3_q[1:0])
            2'b00:   lane = off_q;
            2'b01:   lane = {off_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
        shifted = bus_rdata >> {lane, 3'b000};
        unique case (f3_q[1:0])
            2'b00:   fmt_rdata = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   fmt_rdata = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: fmt_rdata = bus_rdata;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = op_req;
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            f3_q      <= '0;
            off_q     <= '0;
            tmo_cnt   <= '0;
            load_data <= '0;
            lsu_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    lsu_err <= 1'b0;
                    if (op_req) begin
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_we    <= mem_write;
                        bus_wdata <= wd_next;
                        f3_q      <= func3;
                        off_q     <= addr[1:0];
                        tmo_cnt   <= '0;
                        if (trap) begin
                            load_data <= '0;
                            lsu_err   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving in the timeout cycle still completes normally.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            load_data <= fmt_rdata;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        bus_req   <= 1'b0;
                        load_data <= '0;
                        lsu_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    lsu_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
